// File: rtl/bit_serializer.sv
// Parallel-in/serial-out word serializer with a one-entry holding register.
// Back-to-back words stream out on x without gaps; IDLE_BIT is driven between words.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;

  logic             accept;
  logic             last;
  logic             out_bit;
  logic [WIDTH-1:0] sreg_shifted;

  always_comb begin
    last      = (state_q == StShift) && (cnt_q == CntLast);
    din_ready = !hold_full_q && !reset;
    accept    = din_valid && din_ready;
    if (MSB_FIRST) begin
      out_bit      = sreg_q[WIDTH-1];
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      out_bit      = sreg_q[0];
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // Outputs are masked by reset so a word cut off mid-stream never continues.
  always_comb begin
    x_valid     = (state_q == StShift) && !reset;
    x           = x_valid ? out_bit : IDLE_BIT;
    frame_start = x_valid && (cnt_q == '0);
    word_done   = last && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
    end else if (state_q == StIdle) begin
      if (accept) begin
        sreg_q  <= din;
        cnt_q   <= '0;
        state_q <= StShift;
      end
    end else if (!last) begin
      sreg_q <= sreg_shifted;
      cnt_q  <= cnt_q + CntW'(1);
      if (accept) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end
    end else if (hold_full_q) begin
      sreg_q      <= hold_q;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      // Gapless reload straight from din on the final bit.
      sreg_q <= din;
      cnt_q  <= '0;
    end else begin
      state_q <= StIdle;
    end
  end

endmodule
